// File: rtl/lcd_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing_gen_if
// Purpose  : Bundles the pixel-advance enable and the registered LCD timing
//            outputs (DE, syncs, column/row, line/frame strobes) so that the
//            timing generator and the pixel renderer share one port.
// Ports    : i_en           pixel advance enable (renderer/system -> generator)
//            o_de           data enable, high on visible pixels
//            o_hsync        horizontal sync
//            o_vsync        vertical sync
//            o_col          visible column, COL_W bits
//            o_row          visible row, ROW_W bits
//            o_line_start   strobe on first active pixel of each line
//            o_frame_start  strobe on pixel (0,0) of each frame
// Modports : master = timing generator, slave = consumer of the timing
// Revision : 1.0  initial release
// ============================================================================
interface lcd_timing_gen_if #(
   parameter int COL_W = 9,
   parameter int ROW_W = 9
);
   logic             i_en;
   logic             o_de;
   logic             o_hsync;
   logic             o_vsync;
   logic [COL_W-1:0] o_col;
   logic [ROW_W-1:0] o_row;
   logic             o_line_start;
   logic             o_frame_start;

   modport master (
      input  i_en,
      output o_de, o_hsync, o_vsync, o_col, o_row, o_line_start, o_frame_start
   );

   modport slave (
      output i_en,
      input  o_de, o_hsync, o_vsync, o_col, o_row, o_line_start, o_frame_start
   );
endinterface
`default_nettype wire

// File: rtl/lcd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : lcd_timing_gen
// Purpose  : Parametrised DE/HSYNC/VSYNC timing generator for parallel RGB
//            LCD panels. Programmable porches, sync widths and polarities,
//            pixel-clock enable, line/frame strobes, all outputs registered.
// Ports    : i_clk   pixel clock
//            i_rst   synchronous reset, active-high
//            lcd     lcd_timing_gen_if.master (i_en in; o_de, o_hsync,
//                    o_vsync, o_col, o_row, o_line_start, o_frame_start out)
// Revision : 1.0  initial release
// ============================================================================
module lcd_timing_gen #(
   parameter int   H_ACTIVE = 480,
   parameter int   H_FP     = 2,
   parameter int   H_SYNC   = 41,
   parameter int   H_BP     = 2,
   parameter int   V_ACTIVE = 272,
   parameter int   V_FP     = 2,
   parameter int   V_SYNC   = 10,
   parameter int   V_BP     = 6,
   parameter logic HS_POL   = 1'b0,
   parameter logic VS_POL   = 1'b0,
   parameter int   COL_W    = 9,
   parameter int   ROW_W    = 9
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   lcd_timing_gen_if.master      lcd
);

   // State encoding: the numeric order is the traversal order, so a move to
   // a state with an equal or lower code means the sequence has wrapped.
   localparam logic [1:0] ST_SYNC   = 2'd0;
   localparam logic [1:0] ST_BP     = 2'd1;
   localparam logic [1:0] ST_ACTIVE = 2'd2;
   localparam logic [1:0] ST_FP     = 2'd3;

   // Next non-empty state after s. ACTIVE is never empty, so three skips
   // always suffice.
   function automatic logic [1:0] f_next(input logic [1:0] s, input logic [3:0] used);
      logic [1:0] n;
      n = s + 2'd1;
      for (int k = 0; k < 3; k++) begin
         if (!used[n]) n = n + 2'd1;
      end
      return n;
   endfunction

   // First non-empty state starting from SYNC (reset target).
   function automatic logic [1:0] f_first(input logic [3:0] used);
      logic [1:0] n;
      n = ST_SYNC;
      for (int k = 0; k < 3; k++) begin
         if (!used[n]) n = n + 2'd1;
      end
      return n;
   endfunction

   localparam int H_MAX_A = (H_ACTIVE > H_FP) ? H_ACTIVE : H_FP;
   localparam int H_MAX_B = (H_SYNC > H_BP) ? H_SYNC : H_BP;
   localparam int H_MAX   = (H_MAX_A > H_MAX_B) ? H_MAX_A : H_MAX_B;
   localparam int V_MAX_A = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
   localparam int V_MAX_B = (V_SYNC > V_BP) ? V_SYNC : V_BP;
   localparam int V_MAX   = (V_MAX_A > V_MAX_B) ? V_MAX_A : V_MAX_B;

   localparam int H_CNT_W = $clog2(H_MAX + 1);
   localparam int V_CNT_W = $clog2(V_MAX + 1);

   // Bit i set when state i has non-zero length.
   localparam logic [3:0] C_H_USED  = {(H_FP != 0), 1'b1, (H_BP != 0), (H_SYNC != 0)};
   localparam logic [3:0] C_V_USED  = {(V_FP != 0), 1'b1, (V_BP != 0), (V_SYNC != 0)};
   localparam logic [1:0] C_H_FIRST = f_first(C_H_USED);
   localparam logic [1:0] C_V_FIRST = f_first(C_V_USED);

   // Last in-state count of each state; empty states are never entered so
   // their value is irrelevant.
   localparam logic [H_CNT_W-1:0] C_H_LAST_SYNC = H_CNT_W'((H_SYNC > 0) ? H_SYNC - 1 : 0);
   localparam logic [H_CNT_W-1:0] C_H_LAST_BP   = H_CNT_W'((H_BP   > 0) ? H_BP   - 1 : 0);
   localparam logic [H_CNT_W-1:0] C_H_LAST_ACT  = H_CNT_W'(H_ACTIVE - 1);
   localparam logic [H_CNT_W-1:0] C_H_LAST_FP   = H_CNT_W'((H_FP   > 0) ? H_FP   - 1 : 0);
   localparam logic [V_CNT_W-1:0] C_V_LAST_SYNC = V_CNT_W'((V_SYNC > 0) ? V_SYNC - 1 : 0);
   localparam logic [V_CNT_W-1:0] C_V_LAST_BP   = V_CNT_W'((V_BP   > 0) ? V_BP   - 1 : 0);
   localparam logic [V_CNT_W-1:0] C_V_LAST_ACT  = V_CNT_W'(V_ACTIVE - 1);
   localparam logic [V_CNT_W-1:0] C_V_LAST_FP   = V_CNT_W'((V_FP   > 0) ? V_FP   - 1 : 0);
   localparam logic [H_CNT_W-1:0] C_H_ONE       = H_CNT_W'(1);
   localparam logic [V_CNT_W-1:0] C_V_ONE       = V_CNT_W'(1);

   // FSM state and counters
   logic [1:0]         h_state_q, h_state_d;
   logic [H_CNT_W-1:0] h_cnt_q,   h_cnt_d;
   logic [1:0]         v_state_q, v_state_d;
   logic [V_CNT_W-1:0] v_cnt_q,   v_cnt_d;

   // Registered outputs
   logic               de_q,    de_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic [COL_W-1:0]   col_q,   col_d;
   logic [ROW_W-1:0]   row_q,   row_d;
   logic               ls_q,    ls_d;
   logic               fs_q,    fs_d;

   logic               w_h_last, w_h_wrap, w_v_last;
   logic [1:0]         w_h_nxt,  w_v_nxt;
   logic               w_h_act,  w_v_act;

   // ------------------------------------------------------------------
   // State register (also holds the output registers)
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         h_state_q <= C_H_FIRST;
         h_cnt_q   <= '0;
         v_state_q <= C_V_FIRST;
         v_cnt_q   <= '0;
         de_q      <= 1'b0;
         hsync_q   <= ~HS_POL;
         vsync_q   <= ~VS_POL;
         col_q     <= '0;
         row_q     <= '0;
         ls_q      <= 1'b0;
         fs_q      <= 1'b0;
      end else begin
         h_state_q <= h_state_d;
         h_cnt_q   <= h_cnt_d;
         v_state_q <= v_state_d;
         v_cnt_q   <= v_cnt_d;
         de_q      <= de_d;
         hsync_q   <= hsync_d;
         vsync_q   <= vsync_d;
         col_q     <= col_d;
         row_q     <= row_d;
         ls_q      <= ls_d;
         fs_q      <= fs_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_h_last = 1'b0;
      case (h_state_q)
         ST_SYNC:   w_h_last = (h_cnt_q == C_H_LAST_SYNC);
         ST_BP:     w_h_last = (h_cnt_q == C_H_LAST_BP);
         ST_ACTIVE: w_h_last = (h_cnt_q == C_H_LAST_ACT);
         default:   w_h_last = (h_cnt_q == C_H_LAST_FP);
      endcase
      w_v_last = 1'b0;
      case (v_state_q)
         ST_SYNC:   w_v_last = (v_cnt_q == C_V_LAST_SYNC);
         ST_BP:     w_v_last = (v_cnt_q == C_V_LAST_BP);
         ST_ACTIVE: w_v_last = (v_cnt_q == C_V_LAST_ACT);
         default:   w_v_last = (v_cnt_q == C_V_LAST_FP);
      endcase

      w_h_nxt  = f_next(h_state_q, C_H_USED);
      w_v_nxt  = f_next(v_state_q, C_V_USED);
      // End of line: leaving the last non-empty state back towards SYNC.
      w_h_wrap = w_h_last && (w_h_nxt <= h_state_q);

      h_state_d = h_state_q;
      h_cnt_d   = h_cnt_q;
      v_state_d = v_state_q;
      v_cnt_d   = v_cnt_q;
      if (lcd.i_en) begin
         if (w_h_last) begin
            h_state_d = w_h_nxt;
            h_cnt_d   = '0;
         end else begin
            h_cnt_d   = h_cnt_q + C_H_ONE;
         end
         if (w_h_wrap) begin
            if (w_v_last) begin
               v_state_d = w_v_nxt;
               v_cnt_d   = '0;
            end else begin
               v_cnt_d   = v_cnt_q + C_V_ONE;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Output logic (registered one clock later)
   // ------------------------------------------------------------------
   always_comb begin
      w_h_act = (h_state_q == ST_ACTIVE);
      w_v_act = (v_state_q == ST_ACTIVE);
      // Frozen timing: DE and strobes drop, everything else holds.
      de_d    = 1'b0;
      ls_d    = 1'b0;
      fs_d    = 1'b0;
      hsync_d = hsync_q;
      vsync_d = vsync_q;
      col_d   = col_q;
      row_d   = row_q;
      if (lcd.i_en) begin
         de_d    = w_h_act && w_v_act;
         ls_d    = de_d && (h_cnt_q == '0);
         fs_d    = ls_d && (v_cnt_q == '0);
         hsync_d = (h_state_q == ST_SYNC) ? HS_POL : ~HS_POL;
         vsync_d = (v_state_q == ST_SYNC) ? VS_POL : ~VS_POL;
         col_d   = de_d    ? COL_W'(h_cnt_q) : '0;
         row_d   = w_v_act ? ROW_W'(v_cnt_q) : '0;
      end
   end

   assign lcd.o_de          = de_q;
   assign lcd.o_hsync       = hsync_q;
   assign lcd.o_vsync       = vsync_q;
   assign lcd.o_col         = col_q;
   assign lcd.o_row         = row_q;
   assign lcd.o_line_start  = ls_q;
   assign lcd.o_frame_start = fs_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_timing_gen
// Purpose  : Self-checking bench for lcd_timing_gen. A small-parameter
//            instance is checked against a table of hand-computed frame
//            vectors; the default 480x272 instance is checked for line
//            timing, enable freeze and mid-frame reset.
// Revision : 1.0  initial release
// ============================================================================
module tb_lcd_timing_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_d;
   logic rst_s;

   lcd_timing_gen_if #(.COL_W(9), .ROW_W(9)) if_d ();
   lcd_timing_gen_if #(.COL_W(4), .ROW_W(3)) if_s ();

   lcd_timing_gen u_dut_d (
      .i_clk (clk),
      .i_rst (rst_d),
      .lcd   (if_d.master)
   );

   lcd_timing_gen #(
      .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b1), .VS_POL(1'b0), .COL_W(4), .ROW_W(3)
   ) u_dut_s (
      .i_clk (clk),
      .i_rst (rst_s),
      .lcd   (if_s.master)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Small instance: 12-clk lines (SYNC 2, BP 1, ACTIVE 8, FP 1),
   // 7-line frames (SYNC 1, BP 1, ACTIVE 4, FP 1). k = enabled edge index
   // after reset release; the outputs after edge k show position k.
   typedef struct {
      int   k;
      logic de;
      logic hs;
      logic vs;
      int   col;
      int   row;
      logic ls;
      logic fs;
   } vec_t;

   vec_t tbl[$];

   task automatic chk_s(input string tag, input vec_t v);
      chk({tag, " de"},  if_s.o_de,          v.de);
      chk({tag, " hs"},  if_s.o_hsync,       v.hs);
      chk({tag, " vs"},  if_s.o_vsync,       v.vs);
      chk({tag, " col"}, if_s.o_col,         v.col);
      chk({tag, " row"}, if_s.o_row,         v.row);
      chk({tag, " ls"},  if_s.o_line_start,  v.ls);
      chk({tag, " fs"},  if_s.o_frame_start, v.fs);
   endtask

   initial begin
      int   idx;
      int   bad;
      int   hs_hi, hs_rise, n_fs, n_ls, n_de;
      logic prev;
      int   kd, hs_low, vs_low, last_hfall, de_run, last_col, ls_k, guard;
      vec_t rv;

      //                 k    de    hs    vs    col row ls    fs
      tbl.push_back('{  0, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{  1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{  2, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{ 11, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{ 12, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{ 27, 1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1});
      tbl.push_back('{ 28, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0, 1'b0});
      tbl.push_back('{ 34, 1'b1, 1'b0, 1'b1, 7, 0, 1'b0, 1'b0});
      tbl.push_back('{ 35, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{ 39, 1'b1, 1'b0, 1'b1, 0, 1, 1'b1, 1'b0});
      tbl.push_back('{ 70, 1'b1, 1'b0, 1'b1, 7, 3, 1'b0, 1'b0});
      tbl.push_back('{ 71, 1'b0, 1'b0, 1'b1, 0, 3, 1'b0, 1'b0});
      tbl.push_back('{ 72, 1'b0, 1'b1, 1'b1, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{ 84, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 1'b0});
      tbl.push_back('{111, 1'b1, 1'b0, 1'b1, 0, 0, 1'b1, 1'b1});

      rst_d     = 1'b1;
      rst_s     = 1'b1;
      if_d.i_en = 1'b1;
      if_s.i_en = 1'b1;
      tick();
      tick();

      // ---------------- small instance: reset values ----------------
      rv = '{-1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0};
      chk_s("s reset", rv);

      // ---------------- small instance: two frames from table --------
      rst_s = 1'b0;
      idx   = 0;
      for (int k = 0; k <= 111; k++) begin
         tick();
         if (idx < tbl.size() && tbl[idx].k == k) begin
            chk_s($sformatf("s k%0d", k), tbl[idx]);
            idx++;
         end
      end

      // ---------------- small instance: freeze over a line start -----
      repeat (11) tick();                      // k = 122: BP of row 1
      chk("s k122 de", if_s.o_de, 1'b0);
      chk("s k122 row", if_s.o_row, 1);
      if_s.i_en = 1'b0;
      bad = 0;
      repeat (3) begin
         tick();
         if (if_s.o_de !== 1'b0 || if_s.o_line_start !== 1'b0 || if_s.o_row !== 3'd1) bad++;
      end
      chk("s frozen outputs", bad, 0);
      if_s.i_en = 1'b1;
      tick();
      chk("s resume de", if_s.o_de, 1'b1);
      chk("s resume ls", if_s.o_line_start, 1'b1);
      chk("s resume fs", if_s.o_frame_start, 1'b0);
      chk("s resume col", if_s.o_col, 0);
      chk("s resume row", if_s.o_row, 1);
      tick();
      chk("s no repeat ls", if_s.o_line_start, 1'b0);
      chk("s resume col1", if_s.o_col, 1);

      // ---------------- small instance: mid-line reset, frame counts -
      rst_s = 1'b1;
      tick();
      rv = '{-1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0};
      chk_s("s midreset", rv);
      rst_s   = 1'b0;
      prev    = if_s.o_hsync;
      hs_hi   = 0;
      hs_rise = 0;
      n_fs    = 0;
      n_ls    = 0;
      n_de    = 0;
      for (int k = 0; k < 84; k++) begin
         tick();
         if (k == 0) chk("s restart vs", if_s.o_vsync, 1'b0);
         if (if_s.o_hsync === 1'b1) hs_hi++;
         if (prev === 1'b0 && if_s.o_hsync === 1'b1) hs_rise++;
         prev = if_s.o_hsync;
         if (if_s.o_frame_start === 1'b1) n_fs++;
         if (if_s.o_line_start === 1'b1) n_ls++;
         if (if_s.o_de === 1'b1) n_de++;
      end
      chk("s hs high clks/frame", hs_hi, 14);
      chk("s lines/frame", hs_rise, 7);
      chk("s fs/frame", n_fs, 1);
      chk("s ls/frame", n_ls, 4);
      chk("s de clks/frame", n_de, 32);

      // ---------------- default instance: reset values ---------------
      chk("d reset de", if_d.o_de, 1'b0);
      chk("d reset hs", if_d.o_hsync, 1'b1);
      chk("d reset vs", if_d.o_vsync, 1'b1);
      chk("d reset col", if_d.o_col, 0);
      chk("d reset row", if_d.o_row, 0);
      chk("d reset fs", if_d.o_frame_start, 1'b0);

      // ---------------- default: walk to the first active pixel ------
      rst_d = 1'b0;
      tick();
      kd = 0;
      chk("d k0 hs", if_d.o_hsync, 1'b0);
      chk("d k0 vs", if_d.o_vsync, 1'b0);
      prev       = if_d.o_hsync;
      hs_low     = (if_d.o_hsync === 1'b0) ? 1 : 0;
      vs_low     = (if_d.o_vsync === 1'b0) ? 1 : 0;
      last_hfall = 0;
      while (if_d.o_frame_start !== 1'b1 && kd < 10000) begin
         tick();
         kd++;
         if (kd < 525 && if_d.o_hsync === 1'b0) hs_low++;
         if (if_d.o_vsync === 1'b0) vs_low++;
         if (prev === 1'b1 && if_d.o_hsync === 1'b0) last_hfall = kd;
         prev = if_d.o_hsync;
      end
      chk("d hsync low clks", hs_low, 41);
      chk("d vsync low clks", vs_low, 5250);
      chk("d first pixel clk", kd, 8443);
      chk("d hfall to de", kd - last_hfall, 43);
      chk("d first de", if_d.o_de, 1'b1);
      chk("d first ls", if_d.o_line_start, 1'b1);
      chk("d first col", if_d.o_col, 0);
      chk("d first row", if_d.o_row, 0);

      // ---------------- default: DE run and line period --------------
      ls_k     = kd;
      de_run   = 0;
      last_col = -1;
      while (if_d.o_de === 1'b1 && de_run < 1000) begin
         de_run++;
         last_col = int'(if_d.o_col);
         tick();
         kd++;
      end
      chk("d de run", de_run, 480);
      chk("d last col", last_col, 479);
      guard = 0;
      while (if_d.o_line_start !== 1'b1 && guard < 1000) begin
         tick();
         kd++;
         guard++;
      end
      chk("d line period", kd - ls_k, 525);
      chk("d row1", if_d.o_row, 1);

      // ---------------- default: freeze at col 200 -------------------
      n_de  = 0;
      guard = 0;
      while (!(if_d.o_de === 1'b1 && if_d.o_col == 9'd199) && guard < 1000) begin
         if (if_d.o_de === 1'b1) n_de++;
         tick();
         guard++;
      end
      n_de++;                                  // the col 199 pixel
      if_d.i_en = 1'b0;
      bad = 0;
      repeat (100) begin
         tick();
         if (if_d.o_de !== 1'b0 || if_d.o_col !== 9'd199 || if_d.o_line_start !== 1'b0) bad++;
      end
      chk("d frozen outputs", bad, 0);
      if_d.i_en = 1'b1;
      tick();
      chk("d resume col", if_d.o_col, 200);
      chk("d resume de", if_d.o_de, 1'b1);
      guard = 0;
      while (if_d.o_de === 1'b1 && guard < 1000) begin
         n_de++;
         tick();
         guard++;
      end
      chk("d de clks in frozen line", n_de, 480);

      // ---------------- default: reset at row 2, col 300 -------------
      guard = 0;
      while (if_d.o_line_start !== 1'b1 && guard < 1000) begin
         tick();
         guard++;
      end
      chk("d row2", if_d.o_row, 2);
      guard = 0;
      while (if_d.o_col != 9'd300 && guard < 1000) begin
         tick();
         guard++;
      end
      chk("d col300 reached", if_d.o_col, 300);
      rst_d = 1'b1;
      tick();
      chk("d midreset de", if_d.o_de, 1'b0);
      chk("d midreset hs", if_d.o_hsync, 1'b1);
      chk("d midreset vs", if_d.o_vsync, 1'b1);
      chk("d midreset col", if_d.o_col, 0);
      chk("d midreset row", if_d.o_row, 0);
      rst_d = 1'b0;
      tick();
      chk("d restart hs", if_d.o_hsync, 1'b0);
      chk("d restart vs", if_d.o_vsync, 1'b0);
      chk("d restart de", if_d.o_de, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
